spi_mem_ctrl_p: RTL and testbench

SPI_MEM_CTRL_P -- requirements
Module: spi_mem_ctrl_p

---
 rtl/spi_mem_ctrl_p.sv | 207 ++++++++++++++++++++
 tb/tb_spi_mem_ctrl_p.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl_p.sv
// spi_mem_ctrl_p: SPI memory transfer engine (mode 0), one transfer per request.
// Sends a command byte (0x03 read / 0x02 write), an ADDR_BITS address field
// MSB-first, then 1, 2 or 4 data bytes. Write data goes out low byte first,
// MSB-first within each byte. Read bytes are assembled low byte first.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           level request, held by the requester until done
//   is_write        1 = write, 0 = read
//   num_bytes       transfer length (1, 2 or 4; anything else is rejected)
//   target_address  byte address; low ADDR_BITS sent, next bits pick the chip
//   write_value     write data
//   miso            serial data in
//   sclk, mosi      SPI clock (idles low) and serial data out
//   cs_n            active-low chip selects
//   busy            acceptance through done cycle inclusive
//   done, err       one-cycle completion pulse, rejection flag valid with done
//   read_data       assembled read data
//
// state  | meaning
// IDLE   | waiting for start with armed set
// CMD    | shifting the 8-bit command
// ADDR   | shifting the address field
// DATA   | shifting write data / sampling read data
// FINISH | done pulse, chip selects released
module spi_mem_ctrl_p #(
    parameter int NUM_CS    = 2,
    parameter int ADDR_BITS = 24,
    parameter int CLK_DIV   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_write,
    input  logic [2:0]          num_bytes,
    input  logic [31:0]         target_address,
    input  logic [31:0]         write_value,
    input  logic                miso,
    output logic                sclk,
    output logic                mosi,
    output logic [NUM_CS-1:0]   cs_n,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         read_data
);

    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int ASHIFT = 32 - ADDR_BITS;
    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]       ADDR_LAST = 5'(ADDR_BITS - 1);
    localparam logic [7:0]       CMD_READ  = 8'h03;
    localparam logic [7:0]       CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_FINISH} state_t;

    state_t             state;
    logic               armed;
    logic               is_wr_q;
    logic [71:0]        sh;
    logic [4:0]         ph_cnt;
    logic [4:0]         data_last;
    logic [DIV_W-1:0]   div_cnt;

    logic [CS_W-1:0]    chip_idx;
    logic [NUM_CS-1:0]  cs_sel;
    logic [31:0]        wr_stream;
    logic [31:0]        addr_al;
    logic [71:0]        stream;
    logic               len_ok;
    logic [4:0]         data_last_d;
    logic [4:0]         rx_bit;
    logic [4:0]         rx_pos;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^target_address;

    generate
        if (NUM_CS > 1 && ADDR_BITS < 32) begin : g_chip
            assign chip_idx = target_address[ADDR_BITS +: CS_W];
        end else begin : g_single
            assign chip_idx = '0;
        end
    endgenerate

    // Whole transfer as one MSB-first stream: command, address left-aligned,
    // then data packed directly behind the ADDR_BITS address bits.
    always_comb begin
        wr_stream   = '0;
        len_ok      = 1'b1;
        data_last_d = 5'd7;
        if (is_write)
            wr_stream = {write_value[7:0], write_value[15:8],
                         write_value[23:16], write_value[31:24]};
        addr_al = target_address << ASHIFT;
        stream  = {(is_write ? CMD_WRITE : CMD_READ), addr_al, 32'b0}
                | ({40'b0, wr_stream} << ASHIFT);
        case (num_bytes)
            3'd1:    data_last_d = 5'd7;
            3'd2:    data_last_d = 5'd15;
            3'd4:    data_last_d = 5'd31;
            default: len_ok = 1'b0;
        endcase
        cs_sel = '1;
        cs_sel[chip_idx] = 1'b0;
        // Received data bit index -> byte lane in read_data, MSB-first per byte.
        rx_bit = data_last - ph_cnt;
        rx_pos = {rx_bit[4:3], ~rx_bit[2:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            armed     <= 1'b1;
            is_wr_q   <= 1'b0;
            sh        <= '0;
            ph_cnt    <= '0;
            data_last <= '0;
            div_cnt   <= '0;
            cs_n      <= '1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start && armed) begin
                        armed     <= 1'b0;
                        busy      <= 1'b1;
                        is_wr_q   <= is_write;
                        data_last <= data_last_d;
                        if (!is_write)
                            read_data <= '0;
                        if (!len_ok) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= S_CMD;
                            cs_n    <= cs_sel;
                            sclk    <= 1'b0;
                            sh      <= stream;
                            mosi    <= stream[71];
                            ph_cnt  <= 5'd7;
                            div_cnt <= DIV_LOAD;
                        end
                    end else if (!start) begin
                        armed <= 1'b1;
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (!sclk) begin
                        sclk    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else begin
                        // Last edge of the high half: sample, drop sclk, advance bit.
                        sclk    <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        sh      <= {sh[70:0], 1'b0};
                        mosi    <= sh[70];
                        if (state == S_DATA && !is_wr_q)
                            read_data[rx_pos] <= miso;
                        if (ph_cnt != 5'd0) begin
                            ph_cnt <= ph_cnt - 5'd1;
                        end else if (state == S_CMD) begin
                            state  <= S_ADDR;
                            ph_cnt <= ADDR_LAST;
                        end else if (state == S_ADDR) begin
                            state  <= S_DATA;
                            ph_cnt <= data_last;
                        end else begin
                            state <= S_FINISH;
                            cs_n  <= '1;
                            mosi  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    cs_n  <= '1;
                    sclk  <= 1'b0;
                    mosi  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl_p.sv
// Bench for spi_mem_ctrl_p: a default instance (CLK_DIV=1) and a CLK_DIV=4
// instance share inputs; an SPI slave model answers reads from resp[].
module tb_spi_mem_ctrl_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        is_write = 1'b0;
    logic [2:0]  num_bytes = 3'd1;
    logic [31:0] target_address = '0, write_value = '0;
    logic        miso = 1'b0;

    logic        sclk0, mosi0, busy0, done0, err0;
    logic [1:0]  cs_n0;
    logic [31:0] read_data0;
    logic        sclk1, mosi1, busy1, done1, err1;
    logic [1:0]  cs_n1;
    logic [31:0] read_data1;

    always #5 clk = ~clk;

    spi_mem_ctrl_p dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .is_write(is_write),
        .num_bytes(num_bytes), .target_address(target_address),
        .write_value(write_value), .miso(miso), .sclk(sclk0), .mosi(mosi0),
        .cs_n(cs_n0), .busy(busy0), .done(done0), .err(err0),
        .read_data(read_data0));

    spi_mem_ctrl_p #(.NUM_CS(2), .ADDR_BITS(24), .CLK_DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_write(is_write),
        .num_bytes(num_bytes), .target_address(target_address),
        .write_value(write_value), .miso(miso), .sclk(sclk1), .mosi(mosi1),
        .cs_n(cs_n1), .busy(busy1), .done(done1), .err(err1),
        .read_data(read_data1));

    int          sel = 0;
    logic        o_sclk, o_mosi, o_busy, o_done, o_err, cs_idle;
    logic [1:0]  o_cs_n;
    logic [31:0] o_rd;

    always_comb begin
        if (sel == 1) begin
            o_sclk = sclk1; o_mosi = mosi1; o_busy = busy1; o_done = done1;
            o_err = err1; o_cs_n = cs_n1; o_rd = read_data1;
        end else begin
            o_sclk = sclk0; o_mosi = mosi0; o_busy = busy0; o_done = done0;
            o_err = err0; o_cs_n = cs_n0; o_rd = read_data0;
        end
        cs_idle = &o_cs_n;
    end

    int          tests = 0, failed = 0;
    logic [7:0]  resp [4];
    bit          mosi_q [$];
    int          runs [$];
    int          run_len = 0;
    bit          in_xfer = 0;
    logic        prev_sclk = 1'b0;
    int          done_cnt = 0;
    int          idle_mosi_bad = 0;
    logic [31:0] rd_model [2];

    // Slave reply: bit n of the serial frame (command+24 address bits first).
    function automatic logic miso_bit(input int n);
        int d;
        if (n < 32) return 1'b0;
        d = n - 32;
        if (d >= 32) return 1'b0;
        return resp[d / 8][7 - (d % 8)];
    endfunction

    always @(posedge o_sclk) mosi_q.push_back(o_mosi);

    always @(negedge o_sclk or negedge cs_idle) miso = miso_bit(mosi_q.size());

    always begin
        @(posedge clk);
        #1;
        if (o_done) done_cnt++;
        if (cs_idle && o_mosi) idle_mosi_bad++;
        if (!cs_idle) begin
            if (in_xfer && o_sclk == prev_sclk) run_len++;
            else begin
                if (in_xfer) runs.push_back(run_len);
                run_len = 1;
            end
            in_xfer = 1;
            prev_sclk = o_sclk;
        end else if (in_xfer) begin
            runs.push_back(run_len);
            in_xfer = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input int s, input bit w, input logic [2:0] nb,
                           input logic [31:0] addr, input logic [31:0] wv,
                           input int pre, input int hold);
        int div, nbytes, exp_lat, lat, extra;
        bit bad_len, cs_low_seen, sclk_seen;
        logic [1:0]  exp_cs;
        logic [31:0] exp_rd;
        logic [7:0]  exp_b, got_b;
        div     = (s == 1) ? 4 : 1;
        bad_len = !(nb == 3'd1 || nb == 3'd2 || nb == 3'd4);
        nbytes  = int'(nb);
        exp_lat = bad_len ? 1 : 1 + 2 * div * (8 + 24 + 8 * nbytes);
        exp_cs  = addr[24] ? 2'b01 : 2'b10;
        exp_rd  = rd_model[s];
        if (!w) begin
            exp_rd = '0;
            if (!bad_len)
                for (int i = 0; i < nbytes; i++) exp_rd[8*i +: 8] = resp[i];
        end
        repeat (pre) @(negedge clk);
        mosi_q.delete();
        is_write = w; num_bytes = nb; target_address = addr; write_value = wv;
        if (s == 1) start1 = 1'b1; else start0 = 1'b1;
        lat = 0; cs_low_seen = 0; sclk_seen = 0;
        for (int k = 1; k <= exp_lat + 20; k++) begin
            @(posedge clk);
            #1;
            if (o_cs_n !== 2'b11) cs_low_seen = 1;
            if (o_sclk) sclk_seen = 1;
            if (k == 1 && !bad_len) begin
                check("first_cs", o_cs_n, exp_cs);
                check("first_sclk", o_sclk, 0);
                check("first_mosi_cmd7", o_mosi, 0);
                check("first_busy", o_busy, 1);
            end
            if (k == 3) begin
                is_write = ~w;
                num_bytes = 3'($urandom_range(0, 7));
                target_address = $urandom;
                write_value = $urandom;
            end
            if (o_done) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, exp_lat);
        if (lat != 0) begin
            check("done_err", o_err, bad_len);
            check("done_busy", o_busy, 1);
            check("done_cs", o_cs_n, 2'b11);
            check("done_sclk", o_sclk, 0);
            check("done_mosi", o_mosi, 0);
        end
        if (bad_len) begin
            check("rej_cs_low", cs_low_seen, 0);
            check("rej_sclk", sclk_seen, 0);
        end else begin
            check("mosi_bits", mosi_q.size(), 8 * (4 + nbytes));
            for (int i = 0; i < 4 + nbytes; i++) begin
                if (8 * i + 7 < mosi_q.size()) begin
                    got_b = '0;
                    for (int b = 0; b < 8; b++) got_b = {got_b[6:0], mosi_q[8*i+b]};
                    if (i == 0) exp_b = w ? 8'h02 : 8'h03;
                    else if (i < 4) exp_b = addr[8*(3-i) +: 8];
                    else exp_b = w ? wv[8*(i-4) +: 8] : 8'h00;
                    check($sformatf("mosi_byte%0d", i), got_b, exp_b);
                end
            end
            check("read_data", o_rd, exp_rd);
        end
        rd_model[s] = exp_rd;
        @(posedge clk);
        #1;
        check("busy_after", o_busy, 0);
        check("done_after", o_done, 0);
        if (hold > 0) begin
            extra = 0;
            for (int h = 1; h < hold; h++) begin
                @(posedge clk);
                #1;
                if (o_busy || o_done) extra++;
            end
            check("held_start_retrigger", extra, 0);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, bad;
        bit w;
        logic [2:0] nb;
        rd_model[0] = '0;
        rd_model[1] = '0;
        repeat (2) @(negedge clk);
        check("rst_cs", cs_n0, 2'b11);
        check("rst_sclk", sclk0, 0);
        check("rst_mosi", mosi0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_rd", read_data0, 0);
        rst_n = 1'b1;

        // Default read of 4 bytes
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
        do_xfer(0, 1'b0, 3'd4, 32'h0000_0010, 32'h0, 1, 0);
        check("rd_44332211", read_data0, 32'h4433_2211);

        // Write of 2 bytes to chip 1
        do_xfer(0, 1'b1, 3'd2, 32'h0100_0020, 32'h0000_BEEF, 3, 0);
        check("rd_kept_after_write", read_data0, 32'h4433_2211);

        // Illegal length
        do_xfer(0, 1'b0, 3'd3, 32'h0000_0040, 32'h0, 3, 0);

        // Held start then one-cycle low gap
        resp[0] = 8'hA5;
        do_xfer(0, 1'b0, 3'd1, 32'h0000_1234, 32'h0, 3, 10);
        resp[0] = 8'h5C; resp[1] = 8'h7E;
        do_xfer(0, 1'b0, 3'd2, 32'h0100_4321, 32'h0, 1, 0);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: nb = 3'd1;
                1: nb = 3'd2;
                default: nb = 3'd4;
            endcase
            for (int j = 0; j < 4; j++) resp[j] = 8'($urandom);
            do_xfer(0, w, nb, $urandom, $urandom, 3, 0);
        end

        // Reset during bit 20 of a read
        for (int j = 0; j < 4; j++) resp[j] = 8'($urandom);
        repeat (3) @(negedge clk);
        mosi_q.delete();
        is_write = 1'b0; num_bytes = 3'd4; target_address = 32'h0000_0ABC;
        start0 = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (mosi_q.size() >= 20) break;
        end
        check("rst_reach_bit20", (mosi_q.size() >= 20), 1);
        dc = done_cnt;
        rst_n = 1'b0;
        start0 = 1'b0;
        #1;
        check("midrst_cs", cs_n0, 2'b11);
        check("midrst_sclk", sclk0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_mosi", mosi0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_no_done", done_cnt, dc);
        check("midrst_rd", read_data0, 0);
        rd_model[0] = '0;
        rd_model[1] = '0;
        resp[0] = 8'h9D; resp[1] = 8'h01; resp[2] = 8'hF0; resp[3] = 8'h3C;
        do_xfer(0, 1'b0, 3'd4, 32'h0100_0777, 32'h0, 3, 0);

        // CLK_DIV=4 instance, 1-byte read
        repeat (2) @(negedge clk);
        sel = 1;
        runs.delete();
        resp[0] = 8'hC3;
        do_xfer(1, 1'b0, 3'd1, 32'h0000_0100, 32'h0, 3, 0);
        check("div4_runs", runs.size(), 80);
        bad = 0;
        foreach (runs[i]) if (runs[i] != 4) bad++;
        check("div4_half_len", bad, 0);
        check("div4_rd_upper", read_data1[31:8], 24'h0);
        sel = 0;

        check("idle_mosi_zero", idle_mosi_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
